// File: rtl/y86_pkg.sv
// Shared Y86 pipeline definitions: icode encodings, the "no register" id and
// the hazard-controller FSM state type.
package y86_pkg;

    localparam int unsigned ICODE_W = 4;
    localparam int unsigned REG_W   = 4;

    localparam logic [ICODE_W-1:0] ICODE_HALT   = 4'h0;
    localparam logic [ICODE_W-1:0] ICODE_NOP    = 4'h1;
    localparam logic [ICODE_W-1:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [ICODE_W-1:0] ICODE_JXX    = 4'h7;
    localparam logic [ICODE_W-1:0] ICODE_RET    = 4'h9;
    localparam logic [ICODE_W-1:0] ICODE_POPQ   = 4'hB;

    localparam logic [REG_W-1:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_RET_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc cycles and sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = {W{1'b1}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Y86 pipeline hazard controller: mispredict, load-use and ret hazards plus
// halt freeze, with saturating stall/bubble performance counters.
module pipe_hazard_ctrl
    import y86_pkg::*;
#(
    parameter int unsigned CW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    d_icode,
    input  logic [3:0]    d_srcA,
    input  logic [3:0]    d_srcB,
    input  logic [3:0]    e_icode,
    input  logic [3:0]    e_dstM,
    input  logic          e_cnd,
    input  logic          w_halt,
    output logic          f_stall,
    output logic          d_stall,
    output logic          d_bubble,
    output logic          e_bubble,
    output logic          halted,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] bubble_cnt
);

    hz_state_e  r_state;
    hz_state_e  w_state_nxt;
    logic [1:0] r_ret_cnt;
    logic [1:0] w_ret_cnt_nxt;
    logic       w_mispredict;
    logic       w_load_use;
    logic       w_stall_inc;
    logic       w_bubble_inc;

    assign w_mispredict = (e_icode == ICODE_JXX) && !e_cnd;
    assign w_load_use   = ((e_icode == ICODE_MRMOVQ) || (e_icode == ICODE_POPQ))
                          && (e_dstM != RNONE)
                          && ((e_dstM == d_srcA) || (e_dstM == d_srcB));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_ret_cnt <= 2'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_ret_cnt <= w_ret_cnt_nxt;
        end
    end

    // Hazard detection and next-state; halt in writeback overrides everything.
    always_comb begin
        f_stall       = 1'b0;
        d_stall       = 1'b0;
        d_bubble      = 1'b0;
        e_bubble      = 1'b0;
        halted        = 1'b0;
        w_stall_inc   = 1'b0;
        w_bubble_inc  = 1'b0;
        w_state_nxt   = r_state;
        w_ret_cnt_nxt = r_ret_cnt;

        if (!rst_n) begin
            w_state_nxt   = ST_RUN;
            w_ret_cnt_nxt = 2'd0;
        end else if ((r_state == ST_HALTED) || w_halt) begin
            f_stall       = 1'b1;
            d_stall       = 1'b1;
            e_bubble      = 1'b1;
            halted        = (r_state == ST_HALTED);
            w_state_nxt   = ST_HALTED;
            w_ret_cnt_nxt = 2'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mispredict) begin
                        d_bubble     = 1'b1;
                        e_bubble     = 1'b1;
                        w_bubble_inc = 1'b1;
                    end else if (w_load_use) begin
                        f_stall     = 1'b1;
                        d_stall     = 1'b1;
                        e_bubble    = 1'b1;
                        w_stall_inc = 1'b1;
                    end else if (d_icode == ICODE_RET) begin
                        f_stall       = 1'b1;
                        d_bubble      = 1'b1;
                        w_bubble_inc  = 1'b1;
                        w_state_nxt   = ST_RET_WAIT;
                        w_ret_cnt_nxt = 2'd2;
                    end
                end
                ST_RET_WAIT: begin
                    f_stall       = 1'b1;
                    d_bubble      = 1'b1;
                    w_bubble_inc  = 1'b1;
                    w_ret_cnt_nxt = r_ret_cnt - 2'd1;
                    if (r_ret_cnt == 2'd1) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt   = ST_RUN;
                    w_ret_cnt_nxt = 2'd0;
                end
            endcase
        end
    end

    sat_counter #(.W(CW)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CW)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_bubble_inc),
        .count (bubble_cnt)
    );

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter CW, default 32: width of the performance counters.
REQ-002 clk  input  1: single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1: reset, synchronous, active-low.
REQ-004 d_icode  input  4: icode of the instruction in decode.
REQ-005 d_srcA, d_srcB  input  4 each: decode source registers; 4'hF means none.
REQ-006 e_icode  input  4: icode of the instruction in execute.
REQ-007 e_dstM  input  4: memory-load destination of the execute instruction; 4'hF means none.
REQ-008 e_cnd  input  1: condition result of the execute instruction; meaningful only for jXX.
REQ-009 w_halt  input  1: a halt instruction is in writeback this cycle.
REQ-010 f_stall, d_stall  output  1 each: hold the F and D pipeline registers.
REQ-011 d_bubble, e_bubble  output  1 each: load a nop into the D or E pipeline register.
REQ-012 halted  output  1: the pipeline is frozen after a halt.
REQ-013 stall_cnt, bubble_cnt  output  CW each: saturating performance counters.

Function
REQ-014 Icode encodings: HALT=0, NOP=1, MRMOVQ=5, JXX=7, RET=9, POPQ=11.
REQ-015 FSM states: RUN, RET_WAIT, HALTED. A 2-bit counter ret_cnt is used only in RET_WAIT.
REQ-016 Control outputs are combinational from the current inputs and the registered state; the FSM and counters are registered.
REQ-017 Mispredict: e_icode==JXX and e_cnd==0. This asserts d_bubble=1 and e_bubble=1, with no stalls.
REQ-018 Load-use: e_icode is MRMOVQ or POPQ, e_dstM!=4'hF, and e_dstM equals d_srcA or d_srcB. This asserts f_stall=1, d_stall=1 and e_bubble=1.
REQ-019 Ret detection applies in RUN when d_icode==RET and neither mispredict nor load-use is active.
  - Outputs that cycle: f_stall=1, d_bubble=1.
  - Next state: RET_WAIT with ret_cnt=2.
REQ-020 RET_WAIT behaviour:
  - Outputs every cycle: f_stall=1, d_bubble=1, d_stall=0.
  - ret_cnt decrements each cycle.
  - When ret_cnt==1, the next state is RUN.
  - A ret therefore produces exactly 3 consecutive bubble cycles.
REQ-021 Priority in RUN is mispredict > load-use > ret.
  - A ret in D during a mispredict is squashed; the FSM stays in RUN.
  - A ret in D during load-use stalls; the ret is re-evaluated in the next cycle.
REQ-022 Load-use and mispredict are not evaluated in RET_WAIT. E and M contain only bubbles or the ret itself at that point.
REQ-023 HALTED is entered from any state when w_halt==1.
  - HALTED is sticky until reset.
  - Outputs in HALTED: f_stall=1, d_stall=1, d_bubble=0, e_bubble=1, halted=1.
  - w_halt has priority over every other condition in the same cycle.
REQ-024 In RUN with no hazard, all control outputs are 0.
REQ-025 stall_cnt increments by 1 on each cycle where a load-use stall is asserted outside HALTED.
REQ-026 bubble_cnt increments by 1 on each cycle where d_bubble==1 outside HALTED.
REQ-027 Both counters saturate at 2^CW-1 and never wrap.
REQ-028 f_stall and d_bubble together are legal. d_stall and d_bubble are never asserted together.

Reset
REQ-029 When rst_n==0 at posedge clk, the following are forced:
  - state=RUN, ret_cnt=0
  - stall_cnt=0, bubble_cnt=0
  - halted=0
REQ-030 Reset asserted in RET_WAIT or HALTED aborts that state within the same edge. No bubble obligation survives reset.
REQ-031 While rst_n==0, all combinational control outputs are 0.

Structure
REQ-032 Package y86_pkg holds the icode constants, RNONE=4'hF and the FSM state enum; this block imports it.
REQ-033 One sub-module, sat_counter (parameter W; ports clk, rst_n, inc, count), is instantiated twice for stall_cnt and bubble_cnt.
REQ-034 Hazard detection is a single combinational block inside pipe_hazard_ctrl. There are no other sub-modules.

Verification
REQ-035 Load-use: e_icode=5, e_dstM=3, d_srcB=3 for one cycle.
  - Required: f_stall=d_stall=e_bubble=1 for that cycle.
  - Required: stall_cnt goes 0 to 1.
REQ-036 Ret: d_icode=9 in RUN with no other hazard.
  - Required: f_stall=d_bubble=1 for exactly 3 cycles, then all outputs 0.
  - Required: bubble_cnt=3.
REQ-037 Mispredict with ret: e_icode=7, e_cnd=0 and d_icode=9 in the same cycle.
  - Required: d_bubble=e_bubble=1 for one cycle only.
  - Required: the state stays RUN.
REQ-038 Popq followed by ret: e_icode=11, e_dstM=4, d_icode=9, d_srcA=4.
  - Required: a 1-cycle stall, then 3 ret bubble cycles.
  - Required: stall_cnt=1, bubble_cnt=3.
REQ-039 Halt: w_halt=1 during RET_WAIT.
  - Required: HALTED on the next edge, halted=1, and the state holds despite later hazards.
  - Then rst_n=0 for one edge. Required: halted=0, both counters 0, state RUN.
REQ-040 Saturation: with CW=4, force 20 load-use cycles.
  - Required: stall_cnt stays at 15 and never wraps.
